// File: rtl/condicionador_botao_if.sv
// Pedestrian-button conditioner bus: raw button and acknowledge in, conditioned level,
// pulses, request flag and press count out.
interface condicionador_botao_if;
  logic       btn_n;
  logic       ack;
  logic       btn_clean;
  logic       press_pulse;
  logic       long_pulse;
  logic       req;
  logic [7:0] press_count;

  modport master (
    output btn_n,
    output ack,
    input  btn_clean,
    input  press_pulse,
    input  long_pulse,
    input  req,
    input  press_count
  );

  modport slave (
    input  btn_n,
    input  ack,
    output btn_clean,
    output press_pulse,
    output long_pulse,
    output req,
    output press_count
  );
endinterface

// File: rtl/condicionador_botao.sv
// Synchronises and debounces an active-low push-button. Produces a clean level, press and
// long-press pulses, a request flag held until acknowledged, and a saturating press counter.
module condicionador_botao #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input logic                  clk,
  input logic                  rst,
  condicionador_botao_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned CNT_W  = 8;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_END  = LONG_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic              DEB_ONE   = (DEBOUNCE_CYCLES <= 32'd1);

  typedef enum logic [1:0] {
    SOLTO,
    CONFIRMA_PRESS,
    PRESSIONADO,
    CONFIRMA_SOLTA
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [LONG_W-1:0]  r_hold_cnt;
  logic               r_btn_clean;
  logic               r_press_pulse;
  logic               r_long_pulse;
  logic               r_req;
  logic [CNT_W-1:0]   r_press_count;

  logic               w_accept;
  logic               w_release;
  logic               w_held;

  // r_deb_cnt holds the number of stable cycles already seen, including the entry cycle
  assign w_accept  = !r_s2 && ((r_state == SOLTO && DEB_ONE) ||
                               (r_state == CONFIRMA_PRESS && r_deb_cnt == DEB_LAST));
  assign w_release =  r_s2 && ((r_state == PRESSIONADO && DEB_ONE) ||
                               (r_state == CONFIRMA_SOLTA && r_deb_cnt == DEB_LAST));
  assign w_held    = (r_state == PRESSIONADO) || (r_state == CONFIRMA_SOLTA);

  // Synchroniser and debounce state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_state     <= SOLTO;
      r_deb_cnt   <= '0;
      r_btn_clean <= 1'b1;
    end else begin
      r_s1 <= bus.btn_n;
      r_s2 <= r_s1;
      case (r_state)
        SOLTO: begin
          if (!r_s2) begin
            r_deb_cnt <= DEB_W'(1);
            if (w_accept) begin
              r_state     <= PRESSIONADO;
              r_btn_clean <= 1'b0;
            end else begin
              r_state <= CONFIRMA_PRESS;
            end
          end
        end
        CONFIRMA_PRESS: begin
          if (r_s2) begin
            r_state <= SOLTO;
          end else if (w_accept) begin
            r_state     <= PRESSIONADO;
            r_btn_clean <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        PRESSIONADO: begin
          if (r_s2) begin
            r_deb_cnt <= DEB_W'(1);
            if (w_release) begin
              r_state     <= SOLTO;
              r_btn_clean <= 1'b1;
            end else begin
              r_state <= CONFIRMA_SOLTA;
            end
          end
        end
        CONFIRMA_SOLTA: begin
          if (!r_s2) begin
            r_state <= PRESSIONADO;
          end else if (w_release) begin
            r_state     <= SOLTO;
            r_btn_clean <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          r_state     <= SOLTO;
          r_btn_clean <= 1'b1;
        end
      endcase
    end
  end

  // Press pulse, hold timer, request flag and press counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
      r_hold_cnt    <= '0;
      r_req         <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_press_pulse <= w_accept;
      r_long_pulse  <= 1'b0;

      // Hold timer parks at LONG_END so the long pulse fires once per press
      if (w_accept) begin
        r_hold_cnt <= '0;
      end else if (w_held && r_hold_cnt != LONG_END) begin
        r_hold_cnt <= r_hold_cnt + LONG_W'(1);
        if (r_hold_cnt == LONG_LAST) begin
          r_long_pulse <= 1'b1;
        end
      end

      if (w_accept) begin
        r_req <= 1'b1;
      end else if (bus.ack) begin
        r_req <= 1'b0;
      end

      if (w_accept && r_press_count != CNT_MAX) begin
        r_press_count <= r_press_count + CNT_W'(1);
      end
    end
  end

  assign bus.btn_clean   = r_btn_clean;
  assign bus.press_pulse = r_press_pulse;
  assign bus.long_pulse  = r_long_pulse;
  assign bus.req         = r_req;
  assign bus.press_count = r_press_count;

endmodule

// File: tb/tb_condicionador_botao.sv
// Bench for condicionador_botao: directed scenarios plus random button activity, with
// every cycle's outputs checked against a reference model through an expectation queue.
module tb_condicionador_botao;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  condicionador_botao_if bus();

  condicionador_botao #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       clean;
    logic       pulse;
    logic       lng;
    logic       req;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the clean level flips once the last DEB synchronised samples all
  // disagree with it; synchroniser is a plain two-sample delay of btn_n.
  bit   m_s1 = 1'b1;
  bit   m_s2 = 1'b1;
  bit   m_hist[$];
  bit   m_clean = 1'b1;
  bit   m_req = 1'b0;
  int   m_cnt = 0;
  int   m_edge = 0;
  int   m_press_edge = -100000;

  always @(posedge clk) begin : model
    obs_t e;
    bit   nc;
    bit   all_opp;
    bit   pulse;
    bit   lng;
    m_edge++;
    pulse = 1'b0;
    lng   = 1'b0;
    if (rst) begin
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      m_hist.delete();
      for (int i = 0; i < int'(DEB); i++) m_hist.push_back(1'b1);
      m_clean = 1'b1;
      m_req   = 1'b0;
      m_cnt   = 0;
    end else begin
      m_hist.push_back(m_s2);
      void'(m_hist.pop_front());
      all_opp = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] == m_clean) all_opp = 1'b0;
      nc    = all_opp ? ~m_clean : m_clean;
      pulse = m_clean && !nc;
      lng   = !m_clean && ((m_edge - m_press_edge) == int'(LNG));
      if (pulse) begin
        m_press_edge = m_edge;
        m_req = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else if (bus.ack) begin
        m_req = 1'b0;
      end
      m_s2    = m_s1;
      m_s1    = bus.btn_n;
      m_clean = nc;
    end
    e.clean = m_clean;
    e.pulse = pulse;
    e.lng   = lng;
    e.req   = m_req;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    obs_t got;
    obs_t want;
    if (exp_q.size() > 0) begin
      want      = exp_q.pop_front();
      got.clean = bus.btn_clean;
      got.pulse = bus.press_pulse;
      got.lng   = bus.long_pulse;
      got.req   = bus.req;
      got.cnt   = bus.press_count;
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got clean=%b press=%b long=%b req=%b count=%0d required clean=%b press=%b long=%b req=%b count=%0d",
                 $time, got.clean, got.pulse, got.lng, got.req, got.cnt,
                 want.clean, want.pulse, want.lng, want.req, want.cnt);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until press_pulse, counting from the edge after the caller's input change
  task automatic wait_press(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.press_pulse === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_release(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.btn_clean === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin : stim
    int c;
    int n_pulse;
    int n_long;
    int n_clean_low;
    int n_clean_high;
    int p_at;
    int l_at;
    int len;

    rst       = 1'b1;
    bus.btn_n = 1'b0;
    bus.ack   = 1'b0;
    tick(4);
    check("reset_btn_clean", int'(bus.btn_clean), 1);
    check("reset_press_pulse", int'(bus.press_pulse), 0);
    check("reset_req", int'(bus.req), 0);
    check("reset_press_count", int'(bus.press_count), 0);

    // Button held through reset: full sync + debounce delay after release of rst
    rst = 1'b0;
    wait_press(c);
    check("press_after_reset", c, 6);
    bus.btn_n = 1'b1;
    wait_release(c);
    check("release_latency_1", c, 6);
    tick(10);

    // Clean press from idle
    bus.btn_n = 1'b0;
    wait_press(c);
    check("press_latency", c, 6);
    check("press_btn_clean", int'(bus.btn_clean), 0);
    check("press_req", int'(bus.req), 1);
    check("press_count_2", int'(bus.press_count), 2);
    tick(1);
    check("press_pulse_single", int'(bus.press_pulse), 0);
    bus.btn_n = 1'b1;
    tick(12);

    // Bounce: toggle every 2 cycles for 24 cycles
    n_pulse = 0;
    n_clean_low = 0;
    for (int k = 0; k < 12; k++) begin
      bus.btn_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (bus.press_pulse) n_pulse++;
        if (!bus.btn_clean) n_clean_low++;
      end
    end
    bus.btn_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      if (bus.press_pulse) n_pulse++;
      if (!bus.btn_clean) n_clean_low++;
    end
    check("bounce_no_pulse", n_pulse, 0);
    check("bounce_clean_high", n_clean_low, 0);
    check("bounce_count_held", int'(bus.press_count), 2);

    // Long press held 25 cycles
    bus.btn_n = 1'b0;
    p_at = 0;
    l_at = 0;
    n_long = 0;
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      if (bus.press_pulse) p_at = i;
      if (bus.long_pulse) begin
        l_at = i;
        n_long++;
      end
    end
    check("long_offset", l_at - p_at, int'(LNG));
    check("long_once", n_long, 1);
    bus.btn_n = 1'b1;
    wait_release(c);
    check("release_latency_long", c, 6);
    n_pulse = 0;
    n_long = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.press_pulse) n_pulse++;
      if (bus.long_pulse) n_long++;
    end
    check("after_release_no_press", n_pulse, 0);
    check("after_release_no_long", n_long, 0);

    // ack coinciding with a new press: set wins
    check("req_pending_before_ack", int'(bus.req), 1);
    bus.btn_n = 1'b0;
    tick(5);
    bus.ack = 1'b1;
    tick(1);
    check("ack_press_same_edge_pulse", int'(bus.press_pulse), 1);
    check("ack_press_same_edge_req", int'(bus.req), 1);
    bus.ack = 1'b0;
    tick(3);
    bus.ack = 1'b1;
    tick(1);
    check("lone_ack_clears", int'(bus.req), 0);
    bus.ack = 1'b0;
    tick(2);
    bus.ack = 1'b1;
    tick(1);
    check("ack_idle_no_effect", int'(bus.req), 0);
    bus.ack = 1'b0;
    bus.btn_n = 1'b1;
    tick(12);

    // One-cycle glitch while pressed must not re-trigger press
    bus.btn_n = 1'b0;
    wait_press(c);
    tick(3);
    bus.btn_n = 1'b1;
    tick(1);
    bus.btn_n = 1'b0;
    n_pulse = 0;
    n_clean_high = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.press_pulse) n_pulse++;
      if (bus.btn_clean) n_clean_high++;
    end
    check("glitch_no_pulse", n_pulse, 0);
    check("glitch_clean_low", n_clean_high, 0);
    bus.btn_n = 1'b1;
    tick(12);

    // Saturation: 257 clean presses
    for (int k = 0; k < 257; k++) begin
      bus.btn_n = 1'b0;
      tick(8);
      bus.btn_n = 1'b1;
      tick(8);
    end
    check("count_saturated", int'(bus.press_count), 255);

    // Random activity with occasional resets and acks
    for (int k = 0; k < 300; k++) begin
      bus.btn_n = 1'($urandom_range(0, 1));
      bus.ack   = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      len       = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 8));
      tick(len);
    end
    rst       = 1'b0;
    bus.ack   = 1'b0;
    bus.btn_n = 1'b1;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
